// File: rtl/router_ingress_arbiter.sv
// Round-robin arbiter sharing the router ingress port among three packet sources.
// Grants one source per packet, frames it from the header length and drops address-3 packets.
module router_ingress_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    src_req,
  input  logic [DW-1:0] src_data_0,
  input  logic [DW-1:0] src_data_1,
  input  logic [DW-1:0] src_data_2,
  output logic [2:0]    src_ack,
  output logic [2:0]    src_abort,
  output logic [2:0]    grant,
  output logic          rtr_pkt_valid,
  output logic [DW-1:0] rtr_data,
  input  logic          rtr_busy,
  input  logic          rtr_abort,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [2:0] {ARB, HDR, PLD, PAR, DROP} state_t;

  state_t        state, state_n;
  logic [2:0]    grant_n;
  logic [1:0]    last, last_n;
  logic [6:0]    len_cnt, len_n;
  logic [7:0]    drop_n;
  logic [2:0]    win;
  logic [1:0]    gidx;
  logic [DW-1:0] cur;
  logic          ack, abort, in_pkt, hdr_drop;

  always_comb begin
    gidx = 2'd0;
    cur  = '0;
    case (grant)
      3'b001: begin gidx = 2'd0; cur = src_data_0; end
      3'b010: begin gidx = 2'd1; cur = src_data_1; end
      3'b100: begin gidx = 2'd2; cur = src_data_2; end
      default: begin gidx = 2'd0; cur = '0; end
    endcase
  end

  // Search starts at the source after the last one served, wrapping 0,1,2.
  always_comb begin
    win = '0;
    case (last)
      2'd0:    if (src_req[1]) win = 3'b010; else if (src_req[2]) win = 3'b100; else if (src_req[0]) win = 3'b001;
      2'd1:    if (src_req[2]) win = 3'b100; else if (src_req[0]) win = 3'b001; else if (src_req[1]) win = 3'b010;
      default: if (src_req[0]) win = 3'b001; else if (src_req[1]) win = 3'b010; else if (src_req[2]) win = 3'b100;
    endcase
  end

  assign in_pkt   = (state == HDR) || (state == PLD) || (state == PAR);
  assign hdr_drop = (state == HDR) && (cur[1:0] == 2'b11);

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    len_n   = len_cnt;
    drop_n  = drop_cnt;
    ack     = 1'b0;
    abort   = 1'b0;
    case (state)
      ARB: begin
        if (win != '0) begin
          grant_n = win;
          state_n = HDR;
        end
      end
      HDR: begin
        if (rtr_abort) begin
          abort = 1'b1;
        end else if (hdr_drop) begin
          ack     = 1'b1;
          len_n   = {1'b0, cur[7:2]} + 7'd1;
          state_n = DROP;
        end else if (!rtr_busy) begin
          ack     = 1'b1;
          len_n   = {1'b0, cur[7:2]};
          state_n = (cur[7:2] != 6'd0) ? PLD : PAR;
        end
      end
      PLD: begin
        if (rtr_abort) begin
          abort = 1'b1;
        end else if (!rtr_busy) begin
          ack   = 1'b1;
          len_n = len_cnt - 7'd1;
          if (len_cnt == 7'd1) state_n = PAR;
        end
      end
      PAR: begin
        if (rtr_abort) begin
          abort = 1'b1;
        end else if (!rtr_busy) begin
          ack     = 1'b1;
          state_n = ARB;
          grant_n = '0;
          last_n  = gidx;
        end
      end
      DROP: begin
        ack   = 1'b1;
        len_n = len_cnt - 7'd1;
        if (len_cnt == 7'd1) begin
          if (drop_cnt != 8'hFF) drop_n = drop_cnt + 8'd1;
          state_n = ARB;
          grant_n = '0;
          last_n  = gidx;
        end
      end
      default: state_n = ARB;
    endcase
    if (abort) begin
      state_n = ARB;
      grant_n = '0;
      last_n  = gidx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ARB;
      grant    <= '0;
      last     <= 2'd2;
      len_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      last     <= last_n;
      len_cnt  <= len_n;
      drop_cnt <= drop_n;
    end
  end

  assign src_ack       = ack ? grant : 3'b000;
  assign src_abort     = abort ? grant : 3'b000;
  assign rtr_data      = in_pkt ? cur : '0;
  assign rtr_pkt_valid = ((state == HDR) && !hdr_drop) || (state == PLD);

endmodule

// File: tb/tb_router_ingress_arbiter.sv
// Bench for router_ingress_arbiter: byte-queue source models, a monitor comparing
// every acked byte against per-source expected queues, plus directed timing checks.
`timescale 1ns/1ps
module tb_router_ingress_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] src_req;
  logic [7:0] src_data_0, src_data_1, src_data_2;
  logic [2:0] src_ack, src_abort, grant;
  logic       rtr_pkt_valid;
  logic [7:0] rtr_data;
  logic       rtr_busy, rtr_abort;
  logic [7:0] drop_cnt;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } exp_t;

  logic [7:0] src_q [3][$];
  exp_t       exp_q [3][$];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  logic [2:0] prev_g;
  logic [2:0] order [$];
  int         gaps [$];
  int         zrun;
  logic [2:0] rot_exp [4];
  logic [4:0] vb;

  router_ingress_arbiter #(.DW(8)) dut (
    .clk(clk), .reset(reset), .src_req(src_req),
    .src_data_0(src_data_0), .src_data_1(src_data_1), .src_data_2(src_data_2),
    .src_ack(src_ack), .src_abort(src_abort), .grant(grant),
    .rtr_pkt_valid(rtr_pkt_valid), .rtr_data(rtr_data),
    .rtr_busy(rtr_busy), .rtr_abort(rtr_abort), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endfunction

  // Queue a packet on source s and the bytes the router side should show for it.
  task automatic send(input int s, input logic [7:0] hdr, input logic [7:0] base);
    logic       drop;
    logic [7:0] b;
    drop = (hdr[1:0] == 2'b11);
    src_q[s].push_back(hdr);
    exp_q[s].push_back('{data: hdr, valid: !drop});
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = base + 8'(i);
      src_q[s].push_back(b);
      exp_q[s].push_back('{data: drop ? 8'h00 : b, valid: !drop});
    end
    src_q[s].push_back(~base);
    exp_q[s].push_back('{data: drop ? 8'h00 : ~base, valid: 1'b0});
  endtask

  task automatic at_act();
    @(posedge clk);
    #3;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < budget && !idle; n++) begin
      @(negedge clk);
      idle = (grant == 3'b000) && (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0);
    end
    chk(name, 32'(idle), 1);
  endtask

  // Source models and monitor: sample at negedge, consume at posedge+1, present at posedge+4.
  initial begin : drv
    logic [2:0] pop, abt;
    exp_t       e;
    src_req = '0; src_data_0 = '0; src_data_1 = '0; src_data_2 = '0;
    forever begin
      @(negedge clk);
      pop = src_ack;
      abt = src_abort;
      for (int i = 0; i < 3; i++) begin
        if (src_ack[i]) begin
          chk($sformatf("ack_has_expected_s%0d", i), 32'(exp_q[i].size() != 0), 1);
          if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            chk($sformatf("data_s%0d", i), rtr_data, e.data);
            chk($sformatf("pkt_valid_s%0d", i), rtr_pkt_valid, e.valid);
          end
        end
        if (src_abort[i]) exp_q[i].delete();
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (pop[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (abt[i]) src_q[i].delete();
      end
      #3;
      for (int i = 0; i < 3; i++) src_req[i] = (src_q[i].size() != 0);
      src_data_0 = (src_q[0].size() != 0) ? src_q[0][0] : 8'h00;
      src_data_1 = (src_q[1].size() != 0) ? src_q[1][0] : 8'h00;
      src_data_2 = (src_q[2].size() != 0) ? src_q[2][0] : 8'h00;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    reset = 1'b0; rtr_busy = 1'b0; rtr_abort = 1'b0;
    repeat (3) @(posedge clk);
    at_neg();
    chk("reset_grant", grant, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    chk("reset_pkt_valid", rtr_pkt_valid, 0);
    chk("reset_rtr_data", rtr_data, 0);
    chk("reset_ack", src_ack, 0);
    chk("reset_abort", src_abort, 0);

    // Rotation with all three requesting, length-1 packets.
    at_act();
    reset = 1'b1;
    send(0, 8'h04, 8'hD0); send(0, 8'h04, 8'hD8); send(1, 8'h04, 8'hE0); send(2, 8'h04, 8'hF0);
    rot_exp[0] = 3'b001; rot_exp[1] = 3'b010; rot_exp[2] = 3'b100; rot_exp[3] = 3'b001;
    prev_g = '0; zrun = 0;
    for (int c = 0; c < 20; c++) begin
      at_neg();
      if (grant != 3'b000 && prev_g == 3'b000) begin
        order.push_back(grant);
        if (order.size() > 1) gaps.push_back(zrun);
      end
      if (grant == 3'b000) zrun++; else zrun = 0;
      prev_g = grant;
    end
    chk("rot_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk($sformatf("rot_grant%0d", i), order[i], rot_exp[i]);
    foreach (gaps[i]) chk($sformatf("rot_gap%0d", i), gaps[i], 1);

    // Single source, header 0x0D: grant latency and five consecutive acks.
    vb = 5'b11110;
    at_act();
    send(0, 8'h0D, 8'hA1);
    at_neg(); chk("b_pre_grant", grant, 0);
    for (int k = 0; k < 5; k++) begin
      at_neg();
      if (k == 0) chk("b_grant", grant, 3'b001);
      chk($sformatf("b_ack%0d", k), src_ack, 3'b001);
      chk($sformatf("b_valid%0d", k), rtr_pkt_valid, 32'(vb[4-k]));
    end
    at_neg(); chk("b_arb_grant", grant, 0); chk("b_arb_ack", src_ack, 0);

    // Busy stall during payload.
    at_act();
    send(1, 8'h11, 8'hB1);
    at_neg();
    at_neg(); chk("c_grant", grant, 3'b010);
    at_neg(); chk("c_first_pld_ack", src_ack, 3'b010);
    at_act(); rtr_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk($sformatf("c_stall_ack%0d", k), src_ack, 0);
      chk($sformatf("c_stall_data%0d", k), rtr_data, 8'hB2);
      chk($sformatf("c_stall_valid%0d", k), rtr_pkt_valid, 1);
    end
    at_act(); rtr_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg(); chk($sformatf("c_resume_ack%0d", k), src_ack, 3'b010);
    end
    at_neg(); chk("c_arb_grant", grant, 0);

    // Address-3 drop with router busy throughout.
    at_act();
    rtr_busy = 1'b1;
    send(2, 8'h0B, 8'hC1);
    at_neg(); chk("d_drop_cnt_before", drop_cnt, 0);
    at_neg();
    chk("d_grant", grant, 3'b100);
    chk("d_hdr_ack", src_ack, 3'b100);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk($sformatf("d_ack%0d", k), src_ack, 3'b100);
      chk($sformatf("d_valid%0d", k), rtr_pkt_valid, 0);
    end
    at_neg(); chk("d_arb_grant", grant, 0); chk("d_drop_cnt_after", drop_cnt, 1);
    at_act(); rtr_busy = 1'b0;

    // Router abort during payload of source 1.
    at_act();
    send(1, 8'h0D, 8'h61);
    at_neg();
    at_neg(); chk("e_grant", grant, 3'b010);
    at_act();
    send(0, 8'h00, 8'h40); send(2, 8'h00, 8'h50);
    at_neg(); chk("e_pld_ack", src_ack, 3'b010);
    at_act(); rtr_abort = 1'b1;
    at_neg(); chk("e_src_abort", src_abort, 3'b010); chk("e_no_ack", src_ack, 0);
    at_act(); rtr_abort = 1'b0;
    at_neg(); chk("e_grant_cleared", grant, 0);
    at_neg(); chk("e_next_winner", grant, 3'b100);
    wait_idle(30, "e_drain");

    // Zero-length packet to address 2.
    at_act();
    send(0, 8'h02, 8'h71);
    at_neg();
    at_neg(); chk("f_hdr_ack", src_ack, 3'b001); chk("f_hdr_valid", rtr_pkt_valid, 1);
    at_neg(); chk("f_par_ack", src_ack, 3'b001); chk("f_par_valid", rtr_pkt_valid, 0);
    at_neg(); chk("f_arb_grant", grant, 0);

    // Drop counter saturation.
    at_act();
    for (int i = 0; i < 254; i++) send(0, 8'h03, 8'h00);
    wait_idle(2000, "g_drain1");
    chk("g_drop_cnt_255", drop_cnt, 8'hFF);
    at_act();
    send(0, 8'h03, 8'h00); send(0, 8'h03, 8'h00);
    wait_idle(50, "g_drain2");
    chk("g_drop_cnt_sat", drop_cnt, 8'hFF);

    // Reset mid-packet.
    at_act();
    send(0, 8'h0D, 8'h81);
    at_neg();
    at_neg(); chk("h_grant", grant, 3'b001);
    at_neg();
    at_act(); reset = 1'b0;
    at_neg();
    at_act();
    src_q[0].delete(); exp_q[0].delete();
    at_neg();
    chk("h_grant_cleared", grant, 0);
    chk("h_no_abort", src_abort, 0);
    chk("h_no_ack", src_ack, 0);
    chk("h_drop_cnt_cleared", drop_cnt, 0);
    at_act(); reset = 1'b1;
    at_neg();

    for (int i = 0; i < 3; i++) chk($sformatf("exp_empty_s%0d", i), exp_q[i].size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/router_ingress_arbiter.md
# router_ingress_arbiter

Round-robin arbiter that shares the single router ingress port (pkt_valid / data_in / busy) among three packet sources. It grants one source per whole packet, frames the packet from its header length field and drives the router handshake. Packets addressed to the invalid destination 2'b11 are consumed locally and counted. It releases the grant on the parity byte or on a router soft-reset abort, then re-arbitrates.

## Interface
- DW, 8, byte width; header layout fixed: [1:0] destination, [7:2] payload length 0..63
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous, active-low
- src_req  in  3  level request per source; packet waiting, byte presented on src_data_i
- src_data_0 / src_data_1 / src_data_2  in  DW  current byte of each source
- src_ack  out  3  byte of granted source consumed this cycle; source advances on ack
- src_abort  out  3  one-cycle pulse: packet of that source aborted; source discards the rest
- grant  out  3  one-hot registered grant, 0 when idle
- rtr_pkt_valid  out  1  to router pkt_valid
- rtr_data  out  DW  to router data_in
- rtr_busy  in  1  router busy; no byte is accepted while high
- rtr_abort  in  1  OR of the router soft_reset_0..2 for the active destination
- drop_cnt  out  8  saturating count of dropped (addr 2'b11) packets

## Operation
- States: ARB, HDR, PLD, PAR, DROP. Reset state: ARB.
- Reset values: state ARB, grant 0, rr pointer last=2 (source 0 highest priority first), len_cnt 0, drop_cnt 0.
- Outputs src_ack, src_abort, rtr_pkt_valid and rtr_data are 0 while in ARB.
- ARB: if any src_req, winner = first requester after `last` in the order 0,1,2 wrap. Register grant = winner and go to HDR. src_req is sampled only in ARB; deassertion mid-packet is ignored.
- rtr_data = src_data of granted source in HDR/PLD/PAR; 0 otherwise.
- rtr_pkt_valid = (HDR and header[1:0] != 3) or PLD. It is 0 in PAR (the parity byte goes out with pkt_valid low) and 0 in DROP.
- accept = granted state (HDR/PLD/PAR) and ~rtr_busy and ~rtr_abort. src_ack[g] = accept.
- HDR, valid address: on accept, len_cnt = header[7:2]. Next state is PLD if len > 0, else PAR.
- HDR, address 3: ack immediately, ignoring rtr_busy. Load len_cnt = len + 1 (7-bit, covers payload plus parity) and go to DROP.
- PLD: on accept, decrement len_cnt. If the accepted byte had len_cnt == 1, go to PAR.
- PAR: on accept, set last = g, grant = 0, go to ARB.
- DROP: ack every cycle and decrement. When len_cnt == 1 with ack: drop_cnt += 1 (saturating at 255), last = g, go to ARB.
- rtr_abort in HDR/PLD/PAR:
  - No ack that cycle.
  - src_abort[g] pulses in the same cycle.
  - Next cycle: state ARB, grant 0, last = g.
  - rtr_abort is ignored in ARB and DROP.

## Timing
- Grant latency: request seen in ARB at cycle N produces grant and HDR at N+1, so the header is on rtr_data at N+1. There is a minimum 1-cycle ARB gap between packets.
- A byte transfers exactly in cycles where src_ack is high. A source must hold src_data stable until acked.
- Packet of length L with rtr_busy low throughout: L+2 accept cycles (header, L payload, parity), then ARB.
- rtr_busy high stalls any of HDR/PLD/PAR indefinitely with rtr_data held. State does not change.
- After PAR the router is busy (load_parity, check_parity_error). The next header waits in HDR until rtr_busy falls.
- Simultaneous requests: strict rotation. With all three requesting continuously, grants go 0,1,2,0,…
- Reset asserted mid-packet: all state cleared next edge, with no src_abort pulse.

## Test plan
- Single source 0, header 8'h0D (addr 1, len 3), rtr_busy=0 -> grant=001 at N+1; acks on 5 consecutive cycles; rtr_pkt_valid 1,1,1,1,0; back to ARB.
- All three requesting, len 1 each -> grant order 001, 010, 100, 001; one ARB cycle between packets.
- rtr_busy held high 4 cycles during PLD -> no ack for 4 cycles, rtr_data stable, len_cnt unchanged; transfer resumes afterward.
- Header 8'h0B (addr 3, len 2) -> 4 acks over 4 cycles regardless of rtr_busy; rtr_pkt_valid stays 0; drop_cnt 0->1.
- rtr_abort pulse during PLD of source 1 -> src_abort=010 in the same cycle, no ack; grant 0 next cycle; next winner is source 2.
- Header 8'h02 (addr 2, len 0) -> header ack then parity ack with rtr_pkt_valid 0; 256 dropped packets -> drop_cnt holds 255.
